// File: rtl/fdiv_iter.sv
// Iterative IEEE-754 single-precision divider, one quotient bit per cycle, 28-edge latency.
// Optional macro FDIV_SUBNORMAL_EN: normalize subnormal inputs and generate subnormal results.
module fdiv_iter #(
  parameter logic [31:0] NAN_VALUE = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        out_valid,
  output logic [31:0] out
);

  typedef enum logic [1:0] {StIdle, StNorm, StDiv, StRnd} state_e;

  state_e      state_q;
  logic [31:0] a_q, b_q;
  logic [23:0] mb_q;
  logic [24:0] rem_q;
  logic [25:0] quo_q;
  logic [9:0]  exp_q;
  logic [4:0]  cnt_q;
  logic        sign_q, za_q, zb_q;

  logic [7:0]  ea, eb;
  logic [4:0]  na, nb;
  logic [23:0] ma_n, mb_n;
  logic        za_n, zb_n;
  logic [9:0]  exp_n;

  logic [25:0] diff;
  logic        ge;
  logic [24:0] rem_keep;

  logic [24:0] v;
  logic [9:0]  exp_r;
  logic [30:0] mag;
  logic        ovf, flush;
  logic [31:0] res;
  logic        unused_bits;

  assign in_ready = (state_q == StIdle);

`ifdef FDIV_SUBNORMAL_EN
  function automatic logic [4:0] lzc24(input logic [23:0] m);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (m[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  logic [23:0] ma_raw, mb_raw;

  // Subnormals use power 1 and are shifted up until the hidden-bit position is set.
  always_comb begin
    ea     = (a_q[30:23] == 8'd0) ? 8'd1 : a_q[30:23];
    eb     = (b_q[30:23] == 8'd0) ? 8'd1 : b_q[30:23];
    ma_raw = {a_q[30:23] != 8'd0, a_q[22:0]};
    mb_raw = {b_q[30:23] != 8'd0, b_q[22:0]};
    na     = lzc24(ma_raw);
    nb     = lzc24(mb_raw);
    ma_n   = ma_raw << na;
    mb_n   = mb_raw << nb;
    za_n   = (a_q[30:0] == 31'd0);
    zb_n   = (b_q[30:0] == 31'd0);
  end
`else
  // Without subnormal support any exponent-zero operand is a signed zero.
  always_comb begin
    ea   = a_q[30:23];
    eb   = b_q[30:23];
    na   = 5'd0;
    nb   = 5'd0;
    ma_n = {1'b1, a_q[22:0]};
    mb_n = {1'b1, b_q[22:0]};
    za_n = (a_q[30:23] == 8'd0);
    zb_n = (b_q[30:23] == 8'd0);
  end
`endif

  assign exp_n = {2'b00, ea} - {5'd0, na} - {2'b00, eb} + {5'd0, nb} + 10'd127;

  // One restoring step: the remainder stays below 2*Mb, so 25 bits suffice.
  assign diff     = {1'b0, rem_q} - {2'b00, mb_q};
  assign ge       = ~diff[25];
  assign rem_keep = ge ? diff[24:0] : rem_q;

`ifdef FDIV_SUBNORMAL_EN
  logic [9:0] shamt;
`endif

  always_comb begin
    if (quo_q[25]) begin
      v     = quo_q[25:1];
      exp_r = exp_q;
    end else begin
      v     = quo_q[24:0];
      exp_r = exp_q - 10'd1;
    end
    ovf   = !exp_r[9] && (exp_r >= 10'd255);
    flush = 1'b0;
`ifdef FDIV_SUBNORMAL_EN
    shamt = 10'd0;
`endif
    if (exp_r[9] || (exp_r == 10'd0)) begin
`ifdef FDIV_SUBNORMAL_EN
      shamt = 10'd1 - exp_r;
      v     = v >> ((shamt > 10'd25) ? 10'd25 : shamt);
      exp_r = 10'd0;
`else
      flush = 1'b1;
`endif
    end
    // Round half-up; a carry out of the fraction lands in the exponent field.
    mag = {exp_r[7:0], v[23:1]} + {30'd0, v[0]};
    if (za_q && zb_q) begin
      res = NAN_VALUE;
    end else if (zb_q) begin
      res = {sign_q, 8'hFF, 23'h0};
    end else if (za_q) begin
      res = {sign_q, 31'h0};
    end else if (ovf) begin
      res = {sign_q, 8'hFF, 23'h0};
    end else if (flush) begin
      res = {sign_q, 31'h0};
    end else if (mag[30:23] == 8'hFF) begin
      res = {sign_q, 8'hFF, 23'h0};
    end else begin
      res = {sign_q, mag};
    end
  end

  assign unused_bits = v[24] ^ rem_keep[24];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      out       <= 32'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= in1;
            b_q     <= in2;
            state_q <= StNorm;
          end
        end
        StNorm: begin
          rem_q   <= {1'b0, ma_n};
          mb_q    <= mb_n;
          exp_q   <= exp_n;
          sign_q  <= a_q[31] ^ b_q[31];
          za_q    <= za_n;
          zb_q    <= zb_n;
          quo_q   <= 26'd0;
          cnt_q   <= 5'd0;
          state_q <= StDiv;
        end
        StDiv: begin
          rem_q <= {rem_keep[23:0], 1'b0};
          quo_q <= {quo_q[24:0], ge};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd25) state_q <= StRnd;
        end
        StRnd: begin
          out       <= res;
          out_valid <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_iter.sv
// Self-checking bench for fdiv_iter: vector table through a scoreboard plus handshake/reset sequences.
module tb_fdiv_iter;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid;
  logic [31:0] in1, in2, out;

  always #5 clk = ~clk;

  fdiv_iter dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in1      (in1),
    .in2      (in2),
    .out_valid(out_valid),
    .out      (out)
  );

`ifdef FDIV_SUBNORMAL_EN
  localparam bit Sub = 1'b1;
`else
  localparam bit Sub = 1'b0;
`endif

  typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] q; } vec_t;
  typedef struct { logic [31:0] q; int unsigned acc; } exp_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %08h, required %08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: every out_valid pops one expectation and checks value and latency.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out_valid: got out=%08h at cycle %0d, required no pulse", out, cyc);
      end else begin
        e = sb.pop_front();
        check("result", out, e.q);
        check("latency", cyc - e.acc, 32'd28);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "timeout");
  end

  // Called at a negedge with in_ready high; returns at the negedge after the accepting edge.
  task automatic drive_accept(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
    exp_t e;
    in1      = a;
    in2      = b;
    in_valid = 1'b1;
    e.q      = q;
    e.acc    = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    ok = in_ready;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL in_ready_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, w);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
    bit ok;
    wait_ready(ok);
    if (ok) drive_accept(a, b, q);
  endtask

  task automatic wait_ov(input string name, output int unsigned t);
    bit found = 1'b0;
    t = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        t     = cyc;
      end
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: out_valid=0 after 60 cycles, required a pulse", name);
    end
  endtask

  initial begin
    int unsigned t1, t2;
    int          busy, ov_after_rst, w;
    bit          ok;

    vecs.push_back('{a: 32'h40C00000, b: 32'h40000000, q: 32'h40400000});
    vecs.push_back('{a: 32'h3F800000, b: 32'h40400000, q: 32'h3EAAAAAB});
    vecs.push_back('{a: 32'h3F800000, b: 32'h3F800000, q: 32'h3F800000});
    vecs.push_back('{a: 32'hBF800000, b: 32'h00000000, q: 32'hFF800000});
    vecs.push_back('{a: 32'h00000000, b: 32'h00000000, q: 32'h7FC00000});
    vecs.push_back('{a: 32'h80000000, b: 32'h40000000, q: 32'h80000000});
    vecs.push_back('{a: 32'h00800000, b: 32'h40000000, q: Sub ? 32'h00400000 : 32'h0});
    vecs.push_back('{a: 32'h00000001, b: 32'h3F800000, q: Sub ? 32'h00000001 : 32'h0});
    vecs.push_back('{a: 32'h7F000000, b: 32'h3F000000, q: 32'h7F800000});
    vecs.push_back('{a: 32'h7F7FFFFF, b: 32'h3F7FFFFF, q: 32'h7F800000});
    vecs.push_back('{a: 32'hC1200000, b: 32'h40A00000, q: 32'hC0000000});
    vecs.push_back('{a: 32'h3F800000, b: 32'h40000000, q: 32'h3F000000});
    vecs.push_back('{a: 32'h00000003, b: 32'h40000000, q: Sub ? 32'h00000002 : 32'h0});
    vecs.push_back('{a: 32'h3F800000, b: 32'h00400000, q: Sub ? 32'h7F000000 : 32'h7F800000});
    vecs.push_back('{a: 32'h00FFFFFF, b: 32'h40000000, q: Sub ? 32'h00800000 : 32'h0});
    vecs.push_back('{a: 32'h00800000, b: 32'h7F000000, q: 32'h00000000});
    vecs.push_back('{a: 32'h00000000, b: 32'h80400000, q: Sub ? 32'h80000000 : 32'h7FC00000});
    vecs.push_back('{a: 32'h7F800000, b: 32'h3F800000, q: 32'h7F800000});
    vecs.push_back('{a: 32'h3F800000, b: 32'h7F800000, q: Sub ? 32'h00200000 : 32'h0});

    rst      = 1'b1;
    in_valid = 1'b0;
    in1      = 32'd0;
    in2      = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out", out, 32'd0);

    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].q);

    // Operands keep changing with in_valid high while busy; only the first pair counts.
    wait_ready(ok);
    if (ok) begin
      exp_t e;
      in1      = 32'h40C00000;
      in2      = 32'h40000000;
      in_valid = 1'b1;
      e.q      = 32'h40400000;
      e.acc    = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      busy = 0;
      for (int k = 0; k < 28; k++) begin
        @(negedge clk);
        if (!in_ready) busy++;
        in1      = $urandom;
        in2      = $urandom;
        in_valid = (k < 27);
      end
      @(negedge clk);
      check("busy_cycles", busy, 32'd28);
      check("ready_after_result", {31'd0, in_ready}, 32'd1);
    end

    // New accept in the out_valid cycle gives a 29-edge initiation interval.
    send(32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    wait_ov("first_of_pair", t1);
    check("ready_in_out_valid_cycle", {31'd0, in_ready}, 32'd1);
    drive_accept(32'h40C00000, 32'h40000000, 32'h40400000);
    wait_ov("second_of_pair", t2);
    check("initiation_interval", t2 - t1, 32'd29);

    // Reset 10 cycles into an operation discards it.
    send(32'h3F800000, 32'h3F800000, 32'h3F800000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("midop_reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("midop_reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midop_reset_out", out, 32'd0);
    ov_after_rst = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) ov_after_rst++;
    end
    check("no_result_after_reset", ov_after_rst, 32'd0);

    // A fresh operation after the aborted one still works.
    send(32'h3F800000, 32'h40400000, 32'h3EAAAAAB);

    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
